// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART control slice.
//   - tx_arb_state_t : state encoding of the TX write-port arbiter
//   - UART_DATA_W    : default byte width written to the TX buffer
//   - ascii_code_t   : ASCII constants shared with the dec/ascii converters
//   - ascii_hex_digit: nibble -> ASCII hex character
//   - even_parity    : even parity bit of one byte
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } tx_arb_state_t;

  localparam int UART_DATA_W = 8;

  typedef enum logic [7:0] {
    ASCII_LF    = 8'h0A,
    ASCII_CR    = 8'h0D,
    ASCII_SPACE = 8'h20,
    ASCII_ZERO  = 8'h30,
    ASCII_A     = 8'h41
  } ascii_code_t;

  // Upper-case hex character for one nibble.
  function automatic logic [7:0] ascii_hex_digit(input logic [3:0] nib);
    logic [7:0] res;
    if (nib < 4'd10) begin
      res = 8'(ASCII_ZERO) + {4'h0, nib};
    end else begin
      res = 8'(ASCII_A) + {4'h0, nib} - 8'd10;
    end
    return res;
  endfunction

  // Even parity over one byte.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Scans req starting one position above base, wrapping modulo N, and returns
// the first set request.
//   req    in  N   request vector
//   base   in  IW  index of the previous winner (scan starts at base+1)
//   onehot out N   one-hot winner, all zero when no request
//   idx    out IW  encoded winner, zero when no request
//   any    out 1   at least one request present
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  int            cand_s;
  logic [IW-1:0] cand_idx_s;
  logic          found_s;

  // Rotating priority scan; the modulo keeps out-of-range base values safe.
  always_comb begin
    onehot     = '0;
    idx        = '0;
    found_s    = 1'b0;
    cand_s     = 0;
    cand_idx_s = '0;
    for (int k = 1; k <= N; k++) begin
      cand_s     = (int'(base) + k) % N;
      cand_idx_s = IW'(cand_s);
      if (req[cand_idx_s] && !found_s) begin
        onehot[cand_idx_s] = 1'b1;
        idx                = cand_idx_s;
        found_s            = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART TX-buffer write port between N_REQ requesters.
// Round-robin grant, one write per arbitration, followed by GAP_CYCLES idle
// cycles so tx_buf_not_full reflects the write before the next decision.
//   clk             in  1             system clock
//   rst_n           in  1             async active-low reset
//   en              in  1             arbitration enable
//   req             in  N_REQ         level requests, held until gnt
//   req_data        in  N_REQ*DATA_W  byte of requester i at [i*DATA_W +: DATA_W]
//   gnt             out N_REQ         one-hot 1-cycle ack, coincident with tx_write
//   tx_buf_not_full in  1             TX buffer has room
//   tx_write        out 1             1-cycle write strobe
//   tx_send_data    out DATA_W        byte written; holds after the write
//   busy            out 1             high while in WRITE or GAP
//   last_gnt_idx    out $clog2(N_REQ) index of the most recent grant
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int DATA_W     = UART_DATA_W,
  parameter int GAP_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  input  logic                      tx_buf_not_full,
  output logic                      tx_write,
  output logic [DATA_W-1:0]         tx_send_data,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  last_gnt_idx
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(32'd0);
  localparam logic [CW-1:0] CNT_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_RESET = IW'(N_REQ - 1);

  tx_arb_state_t     state_r;
  logic [CW-1:0]     cnt_r;

  logic [N_REQ-1:0]  pick_onehot_s;
  logic [IW-1:0]     pick_idx_s;
  logic              pick_any_s;
  logic [DATA_W-1:0] pick_data_s;
  logic              start_s;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req    (req),
    .base   (last_gnt_idx),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s),
    .any    (pick_any_s)
  );

  // AND-OR mux of the winning requester's byte (onehot is zero or one-hot).
  always_comb begin
    pick_data_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pick_data_s = pick_data_s |
                    (req_data[i*DATA_W +: DATA_W] & {DATA_W{pick_onehot_s[i]}});
    end
  end

  // A new write may start only from IDLE with room in the buffer.
  always_comb begin
    if (state_r == IDLE) begin
      start_s = en & tx_buf_not_full & pick_any_s;
    end else begin
      start_s = 1'b0;
    end
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      gnt          <= '0;
      tx_write     <= 1'b0;
      tx_send_data <= '0;
      busy         <= 1'b0;
      last_gnt_idx <= IDX_RESET;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            tx_write     <= 1'b1;
            gnt          <= pick_onehot_s;
            tx_send_data <= pick_data_s;
            last_gnt_idx <= pick_idx_s;
            busy         <= 1'b1;
            state_r      <= WRITE;
          end else begin
            tx_write <= 1'b0;
            gnt      <= '0;
            busy     <= 1'b0;
          end
        end
        WRITE: begin
          // Strobe lasts one cycle; the buffer flag is ignored from here on.
          tx_write <= 1'b0;
          gnt      <= '0;
          busy     <= 1'b1;
          cnt_r    <= CNT_LOAD;
          state_r  <= GAP;
        end
        GAP: begin
          tx_write <= 1'b0;
          gnt      <= '0;
          if (cnt_r == CNT_ZERO) begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            busy  <= 1'b1;
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          tx_write <= 1'b0;
          gnt      <= '0;
          busy     <= 1'b0;
          cnt_r    <= CNT_ZERO;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule
